// File: rtl/way_select_plru.sv
// One-hot way select for the set-associative way mux: hit way first, else lowest invalid way,
// else the tree pseudo-LRU victim. One PLRU tree per set, updated with the selected way.
module way_select_plru #(
    parameter int NUMBER_WAYS   = 8,
    parameter int NUMBER_SETS   = 64,
    parameter int SET_PTR_WIDTH = 6
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     stall_in,
    input  logic                     access_valid_in,
    input  logic [SET_PTR_WIDTH-1:0] set_idx_in,
    input  logic [NUMBER_WAYS-1:0]   valid_vector_in,
    input  logic [NUMBER_WAYS-1:0]   hit_vector_in,
    input  logic                     plru_clear_in,
    output logic                     sel_valid_out,
    output logic [NUMBER_WAYS-1:0]   sel_out,
    output logic                     hit_out,
    output logic                     multi_hit_out
);

    localparam int LEVELS = $clog2(NUMBER_WAYS);
    localparam int TW     = NUMBER_WAYS - 1;

    logic [TW-1:0] tree [NUMBER_SETS];

    logic [TW-1:0]          tree_rd_p0;
    logic [TW-1:0]          tree_upd_p0;
    logic                   vld_p0;
    logic                   hit_p0;
    logic                   multi_p0;
    logic [NUMBER_WAYS-1:0] sel_p0;
    int                     way_p0;

    function automatic int lowest_set(input logic [NUMBER_WAYS-1:0] v);
        int idx;
        idx = 0;
        for (int i = NUMBER_WAYS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // Walk from the root; a node bit of 1 steers toward the upper-index subtree.
    function automatic int victim_way(input logic [TW-1:0] t);
        int          node;
        logic [TW-1:0] sh;
        node = 0;
        for (int l = 0; l < LEVELS; l++) begin
            sh   = t >> node;
            node = 2 * node + (sh[0] ? 2 : 1);
        end
        return node - TW;
    endfunction

    // Point every node on the path away from the touched way.
    function automatic logic [TW-1:0] plru_touch(input logic [TW-1:0] t, input int way);
        int            n;
        int            parent;
        logic [TW-1:0] mask;
        n = way + TW;
        for (int l = 0; l < LEVELS; l++) begin
            parent  = (n - 1) / 2;
            mask    = '0;
            mask[0] = 1'b1;
            mask    = mask << parent;
            if ((n % 2) == 1) t = t | mask;
            else              t = t & ~mask;
            n = parent;
        end
        return t;
    endfunction

    function automatic logic [NUMBER_WAYS-1:0] one_hot(input int way);
        logic [NUMBER_WAYS-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << way;
    endfunction

    // p0: select way from the current request and the set's tree
    always_comb begin
        tree_rd_p0 = tree[set_idx_in];
        vld_p0     = access_valid_in && !stall_in;
        way_p0     = 0;
        if (|hit_vector_in)          way_p0 = lowest_set(hit_vector_in);
        else if (!(&valid_vector_in)) way_p0 = lowest_set(~valid_vector_in);
        else                          way_p0 = victim_way(tree_rd_p0);
        sel_p0      = vld_p0 ? one_hot(way_p0) : '0;
        hit_p0      = vld_p0 && (|hit_vector_in);
        multi_p0    = vld_p0 && ($countones(hit_vector_in) > 1);
        tree_upd_p0 = plru_touch(tree_rd_p0, way_p0);
    end

    // p1: registered select, held while stalled
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sel_valid_out <= 1'b0;
            sel_out       <= '0;
            hit_out       <= 1'b0;
            multi_hit_out <= 1'b0;
        end else if (!stall_in) begin
            sel_valid_out <= vld_p0;
            sel_out       <= sel_p0;
            hit_out       <= hit_p0;
            multi_hit_out <= multi_p0;
        end
    end

    // Clear wins over a same-edge update of the accessed set.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int s = 0; s < NUMBER_SETS; s++) tree[s] <= '0;
        end else if (plru_clear_in) begin
            for (int s = 0; s < NUMBER_SETS; s++) tree[s] <= '0;
        end else if (vld_p0) begin
            tree[set_idx_in] <= tree_upd_p0;
        end
    end

endmodule

// File: tb/tb_way_select_plru.sv
// Directed bench for way_select_plru: 8 ways, 64 sets, hand-computed PLRU sequences.
module tb_way_select_plru;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       stall_in;
    logic       access_valid_in;
    logic [5:0] set_idx_in;
    logic [7:0] valid_vector_in;
    logic [7:0] hit_vector_in;
    logic       plru_clear_in;
    logic       sel_valid_out;
    logic [7:0] sel_out;
    logic       hit_out;
    logic       multi_hit_out;

    int checks = 0;
    int errors = 0;

    way_select_plru #(.NUMBER_WAYS(8), .NUMBER_SETS(64), .SET_PTR_WIDTH(6)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .stall_in        (stall_in),
        .access_valid_in (access_valid_in),
        .set_idx_in      (set_idx_in),
        .valid_vector_in (valid_vector_in),
        .hit_vector_in   (hit_vector_in),
        .plru_clear_in   (plru_clear_in),
        .sel_valid_out   (sel_valid_out),
        .sel_out         (sel_out),
        .hit_out         (hit_out),
        .multi_hit_out   (multi_hit_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic req(input logic [5:0] s, input logic [7:0] v, input logic [7:0] h);
        access_valid_in = 1'b1;
        set_idx_in      = s;
        valid_vector_in = v;
        hit_vector_in   = h;
    endtask

    task automatic idle();
        access_valid_in = 1'b0;
        valid_vector_in = 8'hFF;
        hit_vector_in   = 8'h00;
    endtask

    // Observed word: {sel_valid, hit, multi_hit, sel[7:0]}
    task automatic test_reset();
        logic [10:0] obs;
        reset_in = 1'b1; stall_in = 1'b0; plru_clear_in = 1'b0;
        set_idx_in = '0; idle();
        tick(); tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== 11'h000) begin
            errors++; $display("FAIL reset_outputs got %h want %h", obs, 11'h000);
        end
        #2 reset_in = 1'b0;
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== 11'h000) begin
            errors++; $display("FAIL idle_after_reset got %h want %h", obs, 11'h000);
        end
    endtask

    task automatic test_plru_sequence();
        logic [7:0]  exp_sel [4] = '{8'h01, 8'h10, 8'h04, 8'h40};
        logic [10:0] obs;
        for (int i = 0; i < 4; i++) begin
            req(6'd3, 8'hFF, 8'h00);
            tick();
            obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
            checks++;
            if (obs !== {3'b100, exp_sel[i]}) begin
                errors++; $display("FAIL plru_miss%0d got %h want %h", i, obs, {3'b100, exp_sel[i]});
            end
        end
        idle();
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== 11'h000) begin
            errors++; $display("FAIL idle_zero got %h want %h", obs, 11'h000);
        end
    endtask

    task automatic test_invalid_fill();
        logic [10:0] obs;
        req(6'd5, 8'hF7, 8'h00);
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b100, 8'h08}) begin
            errors++; $display("FAIL invalid_fill got %h want %h", obs, {3'b100, 8'h08});
        end
        req(6'd5, 8'hFF, 8'h00);
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b100, 8'h10}) begin
            errors++; $display("FAIL victim_after_fill got %h want %h", obs, {3'b100, 8'h10});
        end
    endtask

    task automatic test_hit();
        logic [10:0] obs;
        req(6'd5, 8'hFF, 8'h20);
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b110, 8'h20}) begin
            errors++; $display("FAIL single_hit got %h want %h", obs, {3'b110, 8'h20});
        end
        req(6'd5, 8'hFF, 8'h00);
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b100, 8'h01}) begin
            errors++; $display("FAIL victim_after_hit got %h want %h", obs, {3'b100, 8'h01});
        end
    endtask

    task automatic test_multi_hit();
        logic [10:0] obs;
        req(6'd5, 8'hFF, 8'h24);
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b111, 8'h04}) begin
            errors++; $display("FAIL multi_hit got %h want %h", obs, {3'b111, 8'h04});
        end
    endtask

    task automatic test_stall();
        logic [10:0] obs;
        logic [7:0]  hv [3] = '{8'h00, 8'h80, 8'h03};
        req(6'd5, 8'hFF, 8'h24);
        tick();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req(6'd5, 8'hFF, hv[i]);
            if (i == 2) access_valid_in = 1'b0;
            tick();
            obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
            checks++;
            if (obs !== {3'b111, 8'h04}) begin
                errors++; $display("FAIL stall_hold%0d got %h want %h", i, obs, {3'b111, 8'h04});
            end
        end
        stall_in = 1'b0;
        req(6'd5, 8'hFF, 8'h00);
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b100, 8'h40}) begin
            errors++; $display("FAIL victim_after_stall got %h want %h", obs, {3'b100, 8'h40});
        end
    endtask

    task automatic test_clear();
        logic [10:0] obs;
        req(6'd3, 8'hFF, 8'h00);
        plru_clear_in = 1'b1;
        tick();
        plru_clear_in = 1'b0;
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b100, 8'h02}) begin
            errors++; $display("FAIL clear_uses_old_state got %h want %h", obs, {3'b100, 8'h02});
        end
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b100, 8'h01}) begin
            errors++; $display("FAIL after_clear_set3 got %h want %h", obs, {3'b100, 8'h01});
        end
        req(6'd5, 8'hFF, 8'h00);
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b100, 8'h01}) begin
            errors++; $display("FAIL after_clear_set5 got %h want %h", obs, {3'b100, 8'h01});
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] obs;
        req(6'd3, 8'hFF, 8'h00);
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b100, 8'h10}) begin
            errors++; $display("FAIL pre_reset_victim got %h want %h", obs, {3'b100, 8'h10});
        end
        #2 reset_in = 1'b1;
        #1;
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== 11'h000) begin
            errors++; $display("FAIL async_reset got %h want %h", obs, 11'h000);
        end
        tick();
        #2 reset_in = 1'b0;
        req(6'd3, 8'hFF, 8'h00);
        tick();
        obs = {sel_valid_out, hit_out, multi_hit_out, sel_out};
        checks++;
        if (obs !== {3'b100, 8'h01}) begin
            errors++; $display("FAIL first_after_reset got %h want %h", obs, {3'b100, 8'h01});
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_plru_sequence();
        test_invalid_fill();
        test_hit();
        test_multi_hit();
        test_stall();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
